mem_access_sequencer: RTL and testbench

//  Sits between the control unit and ram512x8 in the multicycle datapath.

---
 rtl/mem_pkg.sv | 50 +++++
 rtl/mem_access_sequencer_load_extender.sv | 22 ++
 rtl/mem_access_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory access sequencer: MIPS load/store opcodes,
// RAM OP mapping, access-size decode and FSM state encoding.
package mem_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    localparam int MEM_BYTES_DEF      = 512;
    localparam int TIMEOUT_CYCLES_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_WAIT  = 3'd2,
        S_FIN   = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    // The RAM only understands the signed load encodings; unsigned loads are
    // fixed up afterwards by the load extender.
    function automatic logic [5:0] map_mem_op(input logic [5:0] op);
        case (op)
            OP_LHU:  return OP_LH;
            OP_LBU:  return OP_LB;
            default: return op;
        endcase
    endfunction

    // Access size in bytes; 0 marks an opcode outside the load/store table.
    function automatic logic [2:0] op_size(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:         return 3'd4;
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            OP_LB, OP_LBU, OP_SB: return 3'd1;
            default:              return 3'd0;
        endcase
    endfunction

    function automatic logic op_is_load(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

endpackage

// File: rtl/mem_access_sequencer_load_extender.sv
// Combinational load-data extension: sign- or zero-extends the low byte/half of
// the raw RAM word according to the original (unmapped) load opcode.
module load_extender
    import mem_pkg::*;
(
    input  logic [5:0]  i_opcode,
    input  logic [31:0] i_raw,
    output logic [31:0] o_ext
);

    always_comb begin
        o_ext = i_raw;
        case (i_opcode)
            OP_LB:   o_ext = {{24{i_raw[7]}}, i_raw[7:0]};
            OP_LBU:  o_ext = {24'h000000, i_raw[7:0]};
            OP_LH:   o_ext = {{16{i_raw[15]}}, i_raw[15:0]};
            OP_LHU:  o_ext = {16'h0000, i_raw[15:0]};
            default: o_ext = i_raw;
        endcase
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// Load/store sequencer between the control unit and ram512x8: validates the
// request, runs the MOV/MOC handshake and returns extended load data.
// Optional WAIT-state abort is enabled by defining MEM_TIMEOUT_EN.
module mem_access_sequencer
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
)
(
    input  logic        Clk,
    input  logic        Clr,
    input  logic        req,
    input  logic        rw,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        align_err,
    output logic        timeout_err,
    output logic        mem_mov,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [5:0]  mem_op,
    input  logic        mem_moc,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  o_dbg_state
);

    state_t      r_state;
    logic        r_rw;
    logic [5:0]  r_opcode;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_first;
    logic        r_busy;
    logic        r_done;
    logic        r_align_err;
    logic        r_mov;
    logic        r_mem_rw;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [5:0]  r_mem_op;
    logic [31:0] r_rdata;

    logic [2:0]  w_size;
    logic        w_is_load;
    logic [32:0] w_last;
    logic        w_bad;
    logic [31:0] w_ext;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] r_cnt;
    logic          r_timeout_err;
`endif

    // Last byte touched is computed one bit wider so addresses near 2^32 cannot wrap into range.
    always_comb begin
        w_size    = op_size(r_opcode);
        w_is_load = op_is_load(r_opcode);
        w_last    = {1'b0, r_addr} + {30'b0, w_size} - 33'd1;
        w_bad     = (w_size == 3'd0) ||
                    (w_is_load != r_rw) ||
                    ((w_size == 3'd4) && (r_addr[1:0] != 2'b00)) ||
                    ((w_size == 3'd2) && r_addr[0]) ||
                    (w_last >= 33'(MEM_BYTES));
    end

    load_extender u_load_extender (
        .i_opcode (r_opcode),
        .i_raw    (mem_rdata),
        .o_ext    (w_ext)
    );

    // RAM handshake: mem_mov is the request, held with stable mem_addr/wdata/op
    // until a qualified mem_moc; MOC in the first WAIT cycle is left over from
    // the previous access and is never trusted.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_state       <= S_IDLE;
            r_rw          <= 1'b0;
            r_opcode      <= 6'd0;
            r_addr        <= 32'd0;
            r_wdata       <= 32'd0;
            r_first       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_align_err   <= 1'b0;
            r_mov         <= 1'b0;
            r_mem_rw      <= 1'b0;
            r_mem_addr    <= 32'd0;
            r_mem_wdata   <= 32'd0;
            r_mem_op      <= 6'd0;
            r_rdata       <= 32'd0;
`ifdef MEM_TIMEOUT_EN
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_done      <= 1'b0;
            r_align_err <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_rw     <= rw;
                        r_opcode <= opcode;
                        r_addr   <= addr;
                        r_wdata  <= wdata;
                        r_busy   <= 1'b1;
                        r_state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_bad) begin
                        r_done      <= 1'b1;
                        r_align_err <= 1'b1;
                        r_state     <= S_ERR;
                    end else begin
                        r_mem_rw    <= r_rw;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= r_wdata;
                        r_mem_op    <= map_mem_op(r_opcode);
                        r_mov       <= 1'b1;
                        r_first     <= 1'b1;
`ifdef MEM_TIMEOUT_EN
                        r_cnt       <= '0;
`endif
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_first <= 1'b0;
                    if (!r_first && mem_moc) begin
                        if (r_rw) begin
                            r_rdata <= w_ext;
                        end
                        r_mov   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        r_mov         <= 1'b0;
                        r_done        <= 1'b1;
                        r_timeout_err <= 1'b1;
                        r_state       <= S_FIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                S_FIN, S_ERR: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_mov   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign rdata       = r_rdata;
    assign align_err   = r_align_err;
    assign mem_mov     = r_mov;
    assign mem_rw      = r_mem_rw;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_op      = r_mem_op;
    assign o_dbg_state = r_state;

`ifdef MEM_TIMEOUT_EN
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a behavioural ram512x8 responder
// (big-endian, byte/half returned in the low bits with junk above).
module tb_mem_access_sequencer;
    import mem_pkg::*;

    logic        Clk, Clr, req, rw;
    logic [5:0]  opcode;
    logic [31:0] addr, wdata;
    logic        busy, done, align_err, timeout_err;
    logic [31:0] rdata;
    logic        mem_mov, mem_rw, mem_moc;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [5:0]  mem_op;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ram [0:511];
    int   moc_delay  = 1;
    logic moc_sticky = 1'b0;
    int   moc_cnt    = 0;

    mem_access_sequencer dut (
        .Clk(Clk), .Clr(Clr), .req(req), .rw(rw), .opcode(opcode),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .align_err(align_err), .timeout_err(timeout_err), .mem_mov(mem_mov),
        .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_op(mem_op), .mem_moc(mem_moc), .mem_rdata(mem_rdata),
        .o_dbg_state(dbg_state)
    );

    // Clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] ram_read(input logic [31:0] a, input logic [5:0] op);
        logic [8:0] b;
        b = a[8:0];
        case (op)
            OP_LW:   return {ram[b], ram[b + 9'd1], ram[b + 9'd2], ram[b + 9'd3]};
            OP_LH:   return {16'hA5A5, ram[b], ram[b + 9'd1]};
            OP_LB:   return {24'hA5A5A5, ram[b]};
            default: return 32'd0;
        endcase
    endfunction

    // RAM responder: MOC rises moc_delay cycles after MOV; in sticky mode a stale
    // MOC from the previous access survives into the first cycle of the new MOV.
    always @(posedge Clk) begin
        #1;
        if (mem_mov) begin
            moc_cnt++;
            mem_moc = (moc_cnt > moc_delay) || (moc_sticky && (moc_cnt == 1) && mem_moc);
            if (mem_moc) mem_rdata = ram_read(mem_addr, mem_op);
        end else begin
            moc_cnt = 0;
            if (!moc_sticky) mem_moc = 1'b0;
        end
    end

    // Driver: called #1 after an edge; returns what was seen on the done cycle,
    // then idles one more cycle so the DUT is back in IDLE.
    task automatic run_access(input logic i_rw, input logic [5:0] i_op,
                              input logic [31:0] i_addr, input logic [31:0] i_wd,
                              input int junk_cycles,
                              output int lat, output logic mov_seen, output logic addr_stable,
                              output logic got_align, output logic got_to,
                              output logic mov_at_done, output logic [31:0] got_rdata);
        int k;
        rw = i_rw; opcode = i_op; addr = i_addr; wdata = i_wd; req = 1'b1;
        @(posedge Clk); #1;
        if (junk_cycles > 0) begin
            rw = 1'b0; opcode = OP_SH; addr = 32'h3; wdata = 32'hFFFF_FFFF;
        end else begin
            req = 1'b0;
        end
        k = 0; mov_seen = 1'b0; addr_stable = 1'b1;
        while (k < 60) begin
            @(posedge Clk); #1;
            k++;
            if (k >= junk_cycles) req = 1'b0;
            if (mem_mov) begin
                mov_seen = 1'b1;
                if (mem_addr !== i_addr) addr_stable = 1'b0;
            end
            if (done) break;
        end
        req = 1'b0;
        lat = done ? k + 1 : -1;
        got_align = align_err; got_to = timeout_err;
        mov_at_done = mem_mov; got_rdata = rdata;
        @(posedge Clk); #1;
    endtask

    int lat;
    logic ms, as, ga, gt, mad;
    logic [31:0] gr;

    task automatic test_reset();
        Clr = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        n_checks++; if ({mem_mov, mem_rw, align_err, timeout_err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {mem_mov, mem_rw, align_err, timeout_err}); end
        n_checks++; if ({mem_addr, mem_wdata, mem_op} !== 70'd0) begin n_fail++; $display("FAIL reset_mem_bus got %h/%h/%b exp 0", mem_addr, mem_wdata, mem_op); end
        n_checks++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
        Clr = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic test_lw();
        run_access(1'b1, OP_LW, 32'h10, 32'h0, 0, lat, ms, as, ga, gt, mad, gr);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL lw_latency got %0d exp 4", lat); end
        n_checks++; if (gr !== 32'h11223344) begin n_fail++; $display("FAIL lw_rdata got %h exp 11223344", gr); end
        n_checks++; if ({ga, gt} !== 2'b00) begin n_fail++; $display("FAIL lw_err_flags got %b exp 00", {ga, gt}); end
        n_checks++; if ({ms, as, mad} !== 3'b110) begin n_fail++; $display("FAIL lw_mov got seen/stable/at_done %b exp 110", {ms, as, mad}); end
        n_checks++; if ({mem_op, mem_rw} !== {OP_LW, 1'b1}) begin n_fail++; $display("FAIL lw_mem_op got %b/%b exp 100011/1", mem_op, mem_rw); end
    endtask

    task automatic test_byte_half();
        logic [5:0]  ops [5]  = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LB};
        logic [31:0] adrs [5] = '{32'h21, 32'h21, 32'h20, 32'h20, 32'h1FF};
        logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF9180, 32'h00009180, 32'h0000007F};
        logic [5:0]  mops [5] = '{OP_LB, OP_LB, OP_LH, OP_LH, OP_LB};
        for (int i = 0; i < 5; i++) begin
            run_access(1'b1, ops[i], adrs[i], 32'h0, 0, lat, ms, as, ga, gt, mad, gr);
            n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL ext%0d_latency got %0d exp 4", i, lat); end
            n_checks++; if (gr !== exps[i]) begin n_fail++; $display("FAIL ext%0d_rdata got %h exp %h", i, gr, exps[i]); end
            n_checks++; if (mem_op !== mops[i]) begin n_fail++; $display("FAIL ext%0d_mem_op got %b exp %b", i, mem_op, mops[i]); end
        end
    endtask

    task automatic test_store();
        run_access(1'b0, OP_SW, 32'h40, 32'hDEADBEEF, 0, lat, ms, as, ga, gt, mad, gr);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL sw_latency got %0d exp 4", lat); end
        n_checks++; if ({mem_wdata, mem_op, mem_rw} !== {32'hDEADBEEF, OP_SW, 1'b0}) begin n_fail++; $display("FAIL sw_mem_bus got %h/%b/%b exp deadbeef/101011/0", mem_wdata, mem_op, mem_rw); end
        n_checks++; if (gr !== 32'h0000007F) begin n_fail++; $display("FAIL sw_rdata_held got %h exp 0000007f", gr); end
        n_checks++; if (ga !== 1'b0) begin n_fail++; $display("FAIL sw_align got %b exp 0", ga); end
        run_access(1'b0, OP_SW, 32'h1FC, 32'h01020304, 0, lat, ms, as, ga, gt, mad, gr);
        n_checks++; if ({lat, ga} !== {32'd4, 1'b0}) begin n_fail++; $display("FAIL sw_top_word got lat %0d align %b exp 4/0", lat, ga); end
        run_access(1'b0, OP_SB, 32'h1FF, 32'h55, 0, lat, ms, as, ga, gt, mad, gr);
        n_checks++; if ({lat, ga} !== {32'd4, 1'b0}) begin n_fail++; $display("FAIL sb_last_byte got lat %0d align %b exp 4/0", lat, ga); end
    endtask

    task automatic test_errors();
        logic        rws  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [5:0]  ops  [8] = '{OP_SH, OP_SW, OP_SW, OP_LH, OP_LW, OP_LW, OP_SB, 6'b000000};
        logic [31:0] adrs [8] = '{32'h3, 32'h1FE, 32'h200, 32'h1FF, 32'h200, 32'h10, 32'h10, 32'h10};
        for (int i = 0; i < 8; i++) begin
            run_access(rws[i], ops[i], adrs[i], 32'hCAFEF00D, 0, lat, ms, as, ga, gt, mad, gr);
            n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL err%0d_latency got %0d exp 2", i, lat); end
            n_checks++; if ({ga, ms} !== 2'b10) begin n_fail++; $display("FAIL err%0d_flags got align/mov %b exp 10", i, {ga, ms}); end
            n_checks++; if (gr !== 32'h0000007F) begin n_fail++; $display("FAIL err%0d_rdata got %h exp 0000007f", i, gr); end
        end
        n_checks++; if ({mem_addr, mem_wdata} !== {32'h1FF, 32'h55}) begin n_fail++; $display("FAIL err_mem_untouched got %h/%h exp 1ff/55", mem_addr, mem_wdata); end
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, OP_LW, 32'h10, 32'h0, 2, lat, ms, as, ga, gt, mad, gr);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL busy_req_latency got %0d exp 4", lat); end
        n_checks++; if ({gr, ga} !== {32'h11223344, 1'b0}) begin n_fail++; $display("FAIL busy_req_ignored got %h/%b exp 11223344/0", gr, ga); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_req_no_queue got busy %b exp 0", busy); end
    endtask

    task automatic test_stale_moc();
        moc_sticky = 1'b1; moc_delay = 1;
        run_access(1'b1, OP_LW, 32'h10, 32'h0, 0, lat, ms, as, ga, gt, mad, gr);
        n_checks++; if (mem_moc !== 1'b1) begin n_fail++; $display("FAIL stale_setup got moc %b exp 1", mem_moc); end
        moc_delay = 3;
        run_access(1'b1, OP_LW, 32'h20, 32'h0, 0, lat, ms, as, ga, gt, mad, gr);
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL stale_latency got %0d exp 6", lat); end
        n_checks++; if (gr !== 32'h91800102) begin n_fail++; $display("FAIL stale_rdata got %h exp 91800102", gr); end
        moc_sticky = 1'b0; moc_delay = 1; mem_moc = 1'b0;
    endtask

    task automatic test_clr_in_wait();
        moc_delay = 20;
        rw = 1'b1; opcode = OP_LW; addr = 32'h10; req = 1'b1;
        @(posedge Clk); #1; req = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        n_checks++; if ({dbg_state, mem_mov} !== {3'd2, 1'b1}) begin n_fail++; $display("FAIL clr_pre_wait got state %0d mov %b exp 2/1", dbg_state, mem_mov); end
        Clr = 1'b1;
        @(posedge Clk); #1;
        Clr = 1'b0;
        n_checks++; if ({busy, mem_mov, done} !== 3'b000) begin n_fail++; $display("FAIL clr_wait_outputs got busy/mov/done %b exp 000", {busy, mem_mov, done}); end
        n_checks++; if ({dbg_state, rdata} !== {3'd0, 32'd0}) begin n_fail++; $display("FAIL clr_wait_state got %0d/%h exp 0/0", dbg_state, rdata); end
        moc_delay = 1;
        run_access(1'b1, OP_LW, 32'h10, 32'h0, 0, lat, ms, as, ga, gt, mad, gr);
        n_checks++; if ({lat, gr} !== {32'd4, 32'h11223344}) begin n_fail++; $display("FAIL clr_then_lw got lat %0d rdata %h exp 4/11223344", lat, gr); end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        moc_delay = 1000;
        run_access(1'b1, OP_LW, 32'h20, 32'h0, 0, lat, ms, as, ga, gt, mad, gr);
        n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL timeout_latency got %0d exp 18", lat); end
        n_checks++; if ({gt, ga, mad} !== 3'b100) begin n_fail++; $display("FAIL timeout_flags got to/align/mov %b exp 100", {gt, ga, mad}); end
        n_checks++; if (gr !== 32'h11223344) begin n_fail++; $display("FAIL timeout_rdata got %h exp 11223344", gr); end
        moc_delay = 1;
    endtask
`endif

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 8'h00;
        ram[9'h10] = 8'h11; ram[9'h11] = 8'h22; ram[9'h12] = 8'h33; ram[9'h13] = 8'h44;
        ram[9'h20] = 8'h91; ram[9'h21] = 8'h80; ram[9'h22] = 8'h01; ram[9'h23] = 8'h02;
        ram[9'h1FF] = 8'h7F;
        Clr = 1'b0; req = 1'b0; rw = 1'b0; opcode = 6'd0; addr = 32'd0; wdata = 32'd0;
        mem_moc = 1'b0; mem_rdata = 32'd0;
        test_reset();
        test_lw();
        test_byte_half();
        test_store();
        test_errors();
        test_back_to_back();
        test_stale_moc();
        test_clr_in_wait();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
